// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage. Holds the PC, looks it up in a direct-mapped
// one-word-per-line instruction cache and, on a miss, fills the line through a
// byte-wide memory port as four little-endian byte reads.
//
// Latency: a hit delivers if_inst combinationally in the same cycle. A miss
// takes six cycles with the grant tied high: one idle cycle, four byte issues,
// and one cycle that writes the line. Each cycle without a grant adds one.
// Backpressure: stall_hold freezes the PC on a hit. rdy low freezes all state.
// mem_addr stays stable until mem_gnt is seen.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   rdy                 global ready; while low nothing changes and mem_re=0
//   stall_hold          downstream IF/ID register is not accepting
//   br_en, br_addr      redirect from ID (word aligned internally)
//   mem_re, mem_addr    byte read request / address (pc + issue count)
//   mem_gnt, mem_rdata  grant for this cycle's read / byte for last granted read
//   if_pc, if_inst      current PC and cached instruction word
//   if_stall_req        high while the PC misses in the cache
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IDX_W    = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        stall_hold,
  input  logic        br_en,
  input  logic [31:0] br_addr,
  input  logic        mem_gnt,
  input  logic [7:0]  mem_rdata,
  output logic        mem_re,
  output logic [31:0] mem_addr,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_stall_req
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  issue_cnt_q, issue_cnt_d;
  logic [1:0]  rx_cnt_q, rx_cnt_d;
  logic        rx_pend_q, rx_pend_d;
  logic [23:0] line_buf_q, line_buf_d;

  // Cache arrays. Only the valid bits are reset; tag and data are don't-care
  // until their valid bit is set by a completed fill.
  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];

  // ---------------------------------------------------------------------------
  // Lookup
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] pc_idx;
  logic [TAG_W-1:0] pc_tag;
  logic             hit;
  logic             fill_we;

  assign pc_idx = pc_q[IDX_W+1:2];
  assign pc_tag = pc_q[31:IDX_W+2];
  assign hit    = valid_q[pc_idx] && (tag_mem[pc_idx] == pc_tag);

  // The last byte lands while in WAIT; it goes straight into the array with the
  // three buffered bytes. A redirect in the same cycle abandons the line, so a
  // line is written only when the fill ran to completion undisturbed.
  assign fill_we = rdy && (state_q == S_WAIT) && rx_pend_q && !br_en;

  assign if_pc        = pc_q;
  assign if_inst      = data_mem[pc_idx];
  assign if_stall_req = ~hit;

  assign mem_re   = rdy && (state_q == S_FETCH);
  assign mem_addr = pc_q + {30'b0, issue_cnt_q};

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    issue_cnt_d = issue_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    rx_pend_d   = rx_pend_q;
    line_buf_d  = line_buf_q;

    if (rdy) begin
      // Byte return for the read granted last rdy cycle. In WAIT the byte is
      // consumed by the array write instead of the buffer.
      if (rx_pend_q) begin
        rx_pend_d = 1'b0;
        if (state_q != S_WAIT) begin
          case (rx_cnt_q)
            2'd0:    line_buf_d[7:0]   = mem_rdata;
            2'd1:    line_buf_d[15:8]  = mem_rdata;
            2'd2:    line_buf_d[23:16] = mem_rdata;
            default: line_buf_d        = line_buf_q;
          endcase
          rx_cnt_d = rx_cnt_q + 2'd1;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (!hit && !br_en) begin
            state_d     = S_FETCH;
            issue_cnt_d = 2'd0;
            rx_cnt_d    = 2'd0;
          end
        end
        S_FETCH: begin
          if (mem_gnt) begin
            issue_cnt_d = issue_cnt_q + 2'd1;
            rx_pend_d   = 1'b1;
            if (issue_cnt_q == 2'd3) begin
              state_d = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (rx_pend_q) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase

      // A redirect overrides whatever the fill was doing; any byte still in
      // flight returns with rx_pend clear and is dropped.
      if (br_en) begin
        state_d     = S_IDLE;
        issue_cnt_d = 2'd0;
        rx_cnt_d    = 2'd0;
        rx_pend_d   = 1'b0;
      end

      if (br_en) begin
        pc_d = {br_addr[31:2], 2'b00};
      end else if (hit && !stall_hold) begin
        pc_d = pc_q + 32'd4;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      issue_cnt_q <= 2'd0;
      rx_cnt_q    <= 2'd0;
      rx_pend_q   <= 1'b0;
      line_buf_q  <= 24'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      issue_cnt_q <= issue_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_pend_q   <= rx_pend_d;
      line_buf_q  <= line_buf_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fill_we) begin
      valid_q[pc_idx] <= 1'b1;
    end
  end

  // An eviction is simply an overwrite of whatever line sits at this index.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_mem[pc_idx]  <= pc_tag;
      data_mem[pc_idx] <= {mem_rdata, line_buf_q};
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios with literal expectations, then a long
// randomized run. A transaction-level model (cache as address-keyed lines,
// fill as a count of granted bytes) predicts every output each cycle.
module tb_if_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        stall_hold = 1'b0;
  logic        br_en = 1'b0;
  logic [31:0] br_addr = 32'h0;
  logic        mem_gnt = 1'b1;
  logic [7:0]  mem_rdata = 8'h0;
  logic        mem_re;
  logic [31:0] mem_addr;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_stall_req;

  if_fetch #(.RESET_PC(RST_PC), .IDX_W(7)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stall_hold(stall_hold),
    .br_en(br_en), .br_addr(br_addr), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
    .mem_re(mem_re), .mem_addr(mem_addr), .if_pc(if_pc), .if_inst(if_inst),
    .if_stall_req(if_stall_req)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Instruction memory contents: fixed program word at 0, hash elsewhere.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [7:0] h;
    case (a)
      32'd0:   return 8'h13;
      32'd1:   return 8'h05;
      32'd2:   return 8'h10;
      32'd3:   return 8'h00;
      default: begin
        h = a[7:0] * 8'd37;
        h = h ^ a[15:8] ^ a[31:24];
        return h + 8'h5A;
      end
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: each of 128 slots remembers which word address it holds.
  // ---------------------------------------------------------------------------
  bit          mv [128];
  logic [31:0] ma [128];
  logic [31:0] md [128];
  logic [31:0] m_pc = RST_PC;
  bit          filling = 1'b0;
  int          granted = 0;
  bit          rsp_v = 1'b0;
  bit          rsp_upd = 1'b0;
  logic [31:0] rsp_a = 32'h0;

  function automatic bit m_hit(input logic [31:0] p);
    int i;
    i = int'(p[8:2]);
    return mv[i] && (ma[i] == p);
  endfunction

  always @(posedge clk or posedge rst) begin
    bit h;
    int i;
    if (rst) begin
      m_pc    = RST_PC;
      filling = 1'b0;
      granted = 0;
      rsp_v   = 1'b0;
      rsp_upd = 1'b0;
      for (int k = 0; k < 128; k++) mv[k] = 1'b0;
    end else begin
      rsp_upd = rdy;
      if (rdy) begin
        // Memory side: remember what the port granted, to return next cycle.
        rsp_v = mem_re && mem_gnt;
        rsp_a = mem_addr;
        h = m_hit(m_pc);
        if (br_en) begin
          filling = 1'b0;
        end else if (filling) begin
          if (granted == 4) begin
            i = int'(m_pc[8:2]);
            mv[i] = 1'b1;
            ma[i] = m_pc;
            md[i] = mem_word(m_pc);
            filling = 1'b0;
          end else if (mem_gnt) begin
            granted++;
          end
        end else if (!h) begin
          filling = 1'b1;
          granted = 0;
        end
        if (br_en) m_pc = {br_addr[31:2], 2'b00};
        else if (h && !stall_hold) m_pc = m_pc + 32'd4;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    bit exp_re;
    exp_re = rdy && filling && (granted < 4);
    chk("m_pc", if_pc, m_pc);
    chk("m_stall", {31'b0, if_stall_req}, {31'b0, !m_hit(m_pc)});
    chk("m_re", {31'b0, mem_re}, {31'b0, exp_re});
    if (exp_re) chk("m_addr", mem_addr, m_pc + granted);
    if (m_hit(m_pc)) chk("m_inst", if_inst, md[int'(m_pc[8:2])]);
  end

  // One clock: move to the next cycle, return the previously granted byte,
  // apply this cycle's inputs and let outputs settle.
  task automatic cyc(input bit br, input logic [31:0] ba, input bit sh, input bit r, input bit g);
    @(posedge clk);
    #2;
    if (rsp_upd) mem_rdata = rsp_v ? mem_byte(rsp_a) : 8'($urandom);
    br_en = br; br_addr = ba; stall_hold = sh; rdy = r; mem_gnt = g;
    #1;
  endtask

  initial begin
    bit found;
    logic [31:0] ba;

    #1 rst = 1'b1;
    #1;
    chk("arst0_re", {31'b0, mem_re}, 32'd0);
    chk("arst0_pc", if_pc, RST_PC);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;

    // Cold start: cycle 0 is idle, bytes issue in cycles 1-4, hit in cycle 6.
    chk("rst_stall", {31'b0, if_stall_req}, 32'd1);
    chk("rst_re", {31'b0, mem_re}, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 1, 1);
      chk("cold_addr", mem_addr, i);
      chk("cold_re", {31'b0, mem_re}, 32'd1);
    end
    cyc(0, 0, 0, 1, 1);
    chk("cold_c5_stall", {31'b0, if_stall_req}, 32'd1);
    chk("cold_c5_re", {31'b0, mem_re}, 32'd0);
    cyc(0, 0, 0, 1, 1);
    chk("cold_c6_stall", {31'b0, if_stall_req}, 32'd0);
    chk("cold_c6_inst", if_inst, 32'h0010_0513);
    chk("cold_c6_pc", if_pc, 32'd0);
    cyc(0, 0, 0, 1, 1);
    chk("cold_c7_pc", if_pc, 32'd4);

    // Grant backpressure on byte 2 of the line at 4.
    cyc(0, 0, 0, 1, 1); chk("bp_a0", mem_addr, 32'd4);
    cyc(0, 0, 0, 1, 1); chk("bp_a1", mem_addr, 32'd5);
    repeat (3) begin
      cyc(0, 0, 0, 1, 0);
      chk("bp_hold_addr", mem_addr, 32'd6);
      chk("bp_hold_re", {31'b0, mem_re}, 32'd1);
    end
    cyc(0, 0, 0, 1, 1); chk("bp_a2", mem_addr, 32'd6);
    cyc(0, 0, 0, 1, 1); chk("bp_a3", mem_addr, 32'd7);
    cyc(0, 0, 0, 1, 1); chk("bp_wait_stall", {31'b0, if_stall_req}, 32'd1);
    cyc(0, 0, 0, 1, 1);
    chk("bp_stall", {31'b0, if_stall_req}, 32'd0);
    chk("bp_inst", if_inst, mem_word(32'd4));
    chk("bp_pc", if_pc, 32'd4);

    // Redirect mid-fill, the cycle after byte 1 of line 8 is granted.
    cyc(0, 0, 0, 1, 1); chk("rd_pc8", if_pc, 32'd8);
    cyc(0, 0, 0, 1, 1); chk("rd_a0", mem_addr, 32'd8);
    cyc(0, 0, 0, 1, 1); chk("rd_a1", mem_addr, 32'd9);
    cyc(1, 32'h0000_0103, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);
    chk("rd_pc", if_pc, 32'h100);
    chk("rd_idle_re", {31'b0, mem_re}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 1, 1);
      chk("rd_fill_addr", mem_addr, 32'h100 + i);
    end
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);
    chk("rd_stall", {31'b0, if_stall_req}, 32'd0);
    chk("rd_inst", if_inst, mem_word(32'h100));
    br_en = 1'b1; br_addr = 32'h8;
    cyc(0, 0, 0, 1, 1);
    chk("rd_8_miss", {31'b0, if_stall_req}, 32'd1);

    // Fill 8 and C, then loop back to 0 once pc reaches 0x10.
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      cyc(0, 0, 0, 1, 1);
      if (if_pc == 32'h10) begin
        br_en = 1'b1; br_addr = 32'h0; found = 1'b1;
      end
    end
    chk("reach_10", {31'b0, found}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 1, 1);
      chk("warm_pc", if_pc, 32'(i * 4));
      chk("warm_stall", {31'b0, if_stall_req}, 32'd0);
      chk("warm_re", {31'b0, mem_re}, 32'd0);
    end
    br_en = 1'b1; br_addr = 32'h0;

    // stall_hold for two cycles on a hit.
    cyc(0, 0, 1, 1, 1);
    chk("sh_pc_a", if_pc, 32'd0); chk("sh_inst_a", if_inst, 32'h0010_0513);
    cyc(0, 0, 1, 1, 1);
    chk("sh_pc_b", if_pc, 32'd0); chk("sh_inst_b", if_inst, 32'h0010_0513);
    cyc(0, 0, 0, 1, 1);
    chk("sh_pc_c", if_pc, 32'd0);
    cyc(0, 0, 0, 1, 1);
    chk("sh_pc_d", if_pc, 32'd4);
    // Redirect beats stall_hold; 0x200 aliases line 0.
    br_en = 1'b1; br_addr = 32'h200; stall_hold = 1'b1;
    cyc(0, 0, 0, 1, 1);
    chk("al_pc", if_pc, 32'h200);
    chk("al_miss", {31'b0, if_stall_req}, 32'd1);
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      cyc(0, 0, 0, 1, 1);
      if (!if_stall_req) found = 1'b1;
    end
    chk("al_filled", {31'b0, found}, 32'd1);
    chk("al_inst", if_inst, mem_word(32'h200));
    br_en = 1'b1; br_addr = 32'h0;
    cyc(0, 0, 0, 1, 1);
    chk("al_0_miss", {31'b0, if_stall_req}, 32'd1);

    // Asynchronous reset in the middle of the refill of 0.
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);
    chk("ar_pre_re", {31'b0, mem_re}, 32'd1);
    rst = 1'b1;
    #1;
    chk("ar_re", {31'b0, mem_re}, 32'd0);
    chk("ar_pc", if_pc, RST_PC);
    chk("ar_stall", {31'b0, if_stall_req}, 32'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("ar_post_miss", {31'b0, if_stall_req}, 32'd1);
    cyc(1, 32'h100, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);
    chk("ar_100_miss", {31'b0, if_stall_req}, 32'd1);

    // Randomized traffic: rdy gaps, grant gaps, stalls, redirects incl. wrap.
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(3))
        0:       ba = ($urandom_range(0, 31) << 2) | $urandom_range(0, 3);
        1:       ba = 32'h200 + ($urandom_range(0, 31) << 2);
        2:       ba = 32'hFFFF_FFF0 + $urandom_range(0, 15);
        default: ba = $urandom;
      endcase
      cyc($urandom_range(19) == 0, ba, $urandom_range(4) == 0,
          $urandom_range(9) != 0, $urandom_range(9) < 7);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
